mem8b_burst_master: RTL and testbench

//  Initiator side of the 8-bit single-port memory interface (clk, rw, add, data_in, data_out).
//  - Accepts read/write burst requests over a valid/ready port.
//  - Sequences the memory's rw/add/data_in and captures data_out.
//  - Returns read data on a valid/ready response stream.
//  - Sits between the test/control logic and the memory8b-style array.

---
 rtl/mem8b_pkg.sv | 15 +
 rtl/mem8b_burst_ctr.sv | 38 +++
 rtl/mem8b_burst_master.sv | 126 ++++++++++++
 tb/tb_mem8b_burst_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem8b_pkg.sv
// Shared widths and FSM state encoding for the 8-bit memory burst master.
package mem8b_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RD_HOLD
    } mem8b_state_e;

endpackage

// File: rtl/mem8b_burst_ctr.sv
// Loadable address / remaining-beat counter pair for one burst.
// The address wraps naturally at 2**ADDR_W; the beat count never goes below zero.
module mem8b_burst_ctr #(
    parameter int ADDR_W = mem8b_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_cnt,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cnt_q;

    // Load at burst start, advance one beat per step
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            addr_q <= load_addr;
            cnt_q  <= load_cnt;
        end else if (step) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign addr_out = addr_q;
    assign last     = (cnt_q == 8'd0);

endmodule

// File: rtl/mem8b_burst_master.sv
// Burst initiator for an 8-bit single-port memory (rw=1 read, rw=0 write).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a burst request, req_ready high
// WR       | committing write beats, one per cycle while wdata_valid
// RD_ISSUE | presenting the read address to the memory
// RD_CAPT  | memory data_out now valid, register it into rsp_data
// RD_HOLD  | rsp beat held stable until the consumer takes it
module mem8b_burst_master #(
    parameter int ADDR_W = mem8b_pkg::ADDR_W,
    parameter int DATA_W = mem8b_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    import mem8b_pkg::*;

    mem8b_state_e      state, state_nx;
    logic              ctr_load;
    logic              ctr_step;
    logic              ctr_last;
    logic [ADDR_W-1:0] addr_q;

    mem8b_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .step      (ctr_step),
        .load_addr (req_addr),
        .load_cnt  (req_len),
        .addr_out  (addr_q),
        .last      (ctr_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, counter control and memory-side strobes.
    // Write beats are gated by rst so a reset edge never commits a write.
    always_comb begin
        state_nx    = state;
        ctr_load    = 1'b0;
        ctr_step    = 1'b0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_rw      = 1'b1;
        mem_data_in = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ctr_load = 1'b1;
                    state_nx = req_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                wdata_ready = !rst;
                mem_data_in = wdata;
                if (wdata_valid && !rst) begin
                    mem_rw   = 1'b0;
                    ctr_step = 1'b1;
                    if (ctr_last) begin
                        state_nx = IDLE;
                    end
                end
            end
            RD_ISSUE: state_nx = RD_CAPT;
            RD_CAPT:  state_nx = RD_HOLD;
            RD_HOLD: begin
                if (rsp_ready) begin
                    if (ctr_last) begin
                        state_nx = IDLE;
                    end else begin
                        ctr_step = 1'b1;
                        state_nx = RD_ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign mem_add = addr_q;

    // Response register: data_out is only trusted in RD_CAPT, then held
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else if (state == RD_CAPT) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_data_out;
            rsp_last  <= ctr_last;
        end else if (state == RD_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem8b_burst_master.sv
// Bench for mem8b_burst_master: a memory8b-style array sits behind the master,
// and a burst-level model (shadow memory, expected response queue, beat counts)
// predicts every handshake, memory strobe and response beat.
module tb_mem8b_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rsp_valid, rsp_last, rsp_ready;
    logic [7:0] rsp_data;
    logic       busy, mem_rw;
    logic [7:0] mem_add, mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem8b_burst_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wdata_valid  (wdata_valid),
        .wdata        (wdata),
        .wdata_ready  (wdata_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .rsp_ready    (rsp_ready),
        .busy         (busy),
        .mem_rw       (mem_rw),
        .mem_add      (mem_add),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // memory8b-style array: writes on every rw=0 edge, reads on rw=1 edges
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (!mem_rw) mem[mem_add] <= mem_data_in;
        else         mem_data_out <= mem[mem_add];
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {logic [7:0] data; logic last;} rsp_t;
    logic [7:0] ref_mem [256];
    rsp_t       rsp_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] wr_base;
    int         wr_idx = 0, wr_left = 0, rd_left = 0, rd_due = 0, rd_acc = 0;
    int         wr_edges = 0, last_lat = -1;
    bit         rd_first = 0, prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    // Compare process: one look per cycle, before the coming edge
    always @(negedge clk) begin : monitor
        bit         hs_q, hs_w, hs_r;
        logic [7:0] a;
        rsp_t       e;
        if (rst) begin
            chk("mem_rw_in_reset", mem_rw, 1'b1);
            wr_left = 0; rd_left = 0; rsp_q.delete(); prev_stall = 0; rd_first = 0;
        end else begin
            hs_q = req_valid && req_ready;
            hs_w = wdata_valid && wdata_ready;
            hs_r = rsp_valid && rsp_ready;
            chk("busy", busy, (wr_left > 0) || (rd_left > 0));
            chk("req_ready", req_ready, !((wr_left > 0) || (rd_left > 0)));
            chk("wdata_ready", wdata_ready, wr_left > 0);
            chk("mem_rw", mem_rw, !hs_w);
            chk("rsp_valid", rsp_valid, (rd_left > 0) && (cyc >= rd_due));
            if (prev_stall) begin
                chk("stall_data", rsp_data, prev_data);
                chk("stall_last", rsp_last, prev_last);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_last  = rsp_last;
            if (!mem_rw) wr_edges++;
            if (rd_first && rsp_valid) begin
                last_lat = cyc - rd_acc;
                rd_first = 0;
            end
            if (hs_w) begin
                a = wr_base + 8'(wr_idx);
                chk("wr_addr", mem_add, a);
                chk("wr_data", mem_data_in, wdata);
                ref_mem[a] = wdata;
                wr_idx++;
                wr_left--;
            end
            if (hs_r) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_extra_beat", rsp_valid, 1'b0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_last", rsp_last, e.last);
                    got_q.push_back(rsp_data);
                    got_last_q.push_back(rsp_last);
                end
                rd_left--;
                if (rd_left > 0) rd_due = cyc + 3;
            end
            if (hs_q) begin
                if (req_write) begin
                    wr_base = req_addr;
                    wr_idx  = 0;
                    wr_left = int'(req_len) + 1;
                end else begin
                    for (int i = 0; i <= int'(req_len); i++) begin
                        a = req_addr + 8'(i);
                        e.data = ref_mem[a];
                        e.last = (i == int'(req_len));
                        rsp_q.push_back(e);
                    end
                    rd_left  = int'(req_len) + 1;
                    rd_due   = cyc + 3;
                    rd_acc   = cyc + 1;
                    rd_first = 1;
                end
            end
        end
    end

    // ---------------- drivers (called at posedge+1) ----------------
    logic [7:0] wq[$];

    task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] len, input bit early_w);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        if (wr && early_w) begin
            wdata_valid = 1'b1;
            wdata       = wq[0];
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 200);
        chk("req_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wdata_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input bit early_w,
                            input int gap_at, input int gap_len, input bit rnd_gaps, input int abort_at);
        int n, g;
        issue(1'b1, addr, len, early_w);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                wdata_valid = 1'b1; wdata = wq[i]; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; wdata_valid = 1'b0;
                return;
            end
            g = (i == gap_at) ? gap_len : (rnd_gaps ? int'($urandom_range(0, 2)) : 0);
            if (g > 0) begin
                wdata_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            wdata_valid = 1'b1;
            wdata       = wq[i];
            n = 0;
            do begin @(negedge clk); n++; end while (!wdata_ready && n < 50);
            chk("wbeat_accept", wdata_ready, 1'b1);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
    endtask

    // mode 0: rsp_ready high, 1: first beat stalled 5 cycles, 2: random rsp_ready
    task automatic do_read(input logic [7:0] addr, input logic [7:0] len, input int mode);
        int n;
        got_q.delete();
        got_last_q.delete();
        rsp_ready = (mode == 0);
        issue(1'b0, addr, len, 1'b0);
        if (mode == 1) begin
            n = 0;
            while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
            chk("rsp_first_valid", rsp_valid, 1'b1);
            repeat (5) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
        end
        n = 0;
        while (rd_left > 0 && n < 5000) begin
            @(posedge clk); #1;
            if (mode == 2) rsp_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("rd_complete", rsp_valid, 1'b0);
        chk("rd_beats_left", rd_left, 0);
        rsp_ready = 1'b1;
    endtask

    task automatic check_seq(input string name, input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3, input int cnt);
        chk({name, "_count"}, got_q.size(), cnt);
        if (got_q.size() == cnt) begin
            if (cnt > 0) chk({name, "_b0"}, got_q[0], v0);
            if (cnt > 1) chk({name, "_b1"}, got_q[1], v1);
            if (cnt > 2) chk({name, "_b2"}, got_q[2], v2);
            if (cnt > 3) chk({name, "_b3"}, got_q[3], v3);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         w0, mism;
        logic [7:0] ra, rl, old42;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b1;
        mem_data_out = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_wdata_ready", wdata_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b1);
        chk("rst_mem_add", mem_add, 8'h00);
        chk("rst_mem_data_in", mem_data_in, 8'h00);
        @(posedge clk); #1;

        // idle safety
        repeat (50) begin @(posedge clk); #1; end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("idle_mem_unchanged", mism, 0);

        // single write then read, data presented early on the request cycle
        wq.delete(); wq.push_back(8'hA5);
        do_write(8'h10, 8'd0, 1'b1, -1, 0, 1'b0, -1);
        chk("t1_mem", mem[8'h10], 8'hA5);
        do_read(8'h10, 8'd0, 0);
        check_seq("t1_rd", 8'hA5, 8'h00, 8'h00, 8'h00, 1);
        if (got_last_q.size() == 1) chk("t1_last", got_last_q[0], 1'b1);
        chk("t1_latency", last_lat, 2);

        // write burst with a 2-cycle wdata_valid gap
        wq.delete(); for (int i = 1; i <= 4; i++) wq.push_back(8'(i));
        w0 = wr_edges;
        do_write(8'h20, 8'd3, 1'b0, 2, 2, 1'b0, -1);
        chk("t2_write_edges", wr_edges - w0, 4);
        do_read(8'h20, 8'd3, 0);
        check_seq("t2_rd", 8'h01, 8'h02, 8'h03, 8'h04, 4);

        // wrap-around
        wq.delete(); for (int i = 0; i < 4; i++) wq.push_back(8'h11 + 8'(i));
        do_write(8'hFE, 8'd3, 1'b0, -1, 0, 1'b0, -1);
        chk("t3_mem_fe", mem[8'hFE], 8'h11);
        chk("t3_mem_ff", mem[8'hFF], 8'h12);
        chk("t3_mem_00", mem[8'h00], 8'h13);
        chk("t3_mem_01", mem[8'h01], 8'h14);
        do_read(8'hFE, 8'd3, 0);
        check_seq("t3_rd", 8'h11, 8'h12, 8'h13, 8'h14, 4);

        // backpressure on the first beat
        do_read(8'h20, 8'd2, 1);
        check_seq("t4_rd", 8'h01, 8'h02, 8'h03, 8'h00, 3);
        if (got_last_q.size() == 3) begin
            chk("t4_last0", got_last_q[0], 1'b0);
            chk("t4_last1", got_last_q[1], 1'b0);
            chk("t4_last2", got_last_q[2], 1'b1);
        end

        // reset during beat 2 of an 8-beat write
        wq.delete(); wq.push_back(8'h5A);
        do_write(8'h42, 8'd0, 1'b0, -1, 0, 1'b0, -1);
        old42 = mem[8'h42];
        wq.delete(); for (int i = 0; i < 8; i++) wq.push_back(8'h80 + 8'(i));
        do_write(8'h40, 8'd7, 1'b0, -1, 0, 1'b0, 2);
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_req_ready", req_ready, 1'b1);
        chk("t5_mem_rw", mem_rw, 1'b1);
        chk("t5_mem_40", mem[8'h40], 8'h80);
        chk("t5_mem_41", mem[8'h41], 8'h81);
        chk("t5_mem_42", mem[8'h42], old42);
        @(posedge clk); #1;
        do_read(8'h40, 8'd0, 0);
        check_seq("t5_rd", 8'h80, 8'h00, 8'h00, 8'h00, 1);

        // randomized bursts
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i <= int'(rl); i++) wq.push_back(8'($urandom));
                do_write(ra, rl, 1'($urandom_range(0, 1)), -1, 0, 1'b1, -1);
            end else begin
                do_read(ra, rl, 2);
            end
        end

        // full 256-beat sweep
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(8'($urandom));
        ra = 8'($urandom);
        w0 = wr_edges;
        do_write(ra, 8'd255, 1'b0, -1, 0, 1'b0, -1);
        chk("sweep_write_edges", wr_edges - w0, 256);
        do_read(ra, 8'd255, 2);
        chk("sweep_read_count", got_q.size(), 256);

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("final_mem", mism, 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
